// File: rtl/uop_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : uop_sequencer
//  Purpose  : Microprogram sequencer for the curve arithmetic engines. It
//             steps a program counter through one of NUM_PROGS programs in an
//             external synchronous ROM (addressed {prog_sel, pc}). It hands
//             each micro-operation to the executor over a valid/ack handshake
//             and stops on the RDY opcode, or flags err on address overrun.
//  Revision : 1.0  initial release
//
//  Ports
//    clk        in   clock
//    rst        in   synchronous active-high reset
//    ena        in   start request, sampled only while rdy=1
//    prog_sel   in   program select, sampled together with ena
//    rdy        out  idle / done level
//    err        out  sticky overrun flag, cleared by the next start
//    rom_addr   out  registered ROM address {sel, pc}
//    rom_data   in   ROM word, valid one clock after rom_addr changes
//    uop        out  registered micro-operation presented to the executor
//    uop_valid  out  uop is being presented
//    uop_ack    in   executor has completed uop (ignored while uop_valid=0)
//    uop_cnt    out  number of uops acknowledged in the current run
// ============================================================================
module uop_sequencer #(
  parameter int                  ADDR_W     = 6,
  parameter int                  SEL_W      = 2,
  parameter int                  UOP_W      = 20,
  parameter int                  OPCODE_W   = 4,
  parameter logic [OPCODE_W-1:0] OPCODE_RDY = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ena,
  input  logic [SEL_W-1:0]        prog_sel,
  output logic                    rdy,
  output logic                    err,
  output logic [SEL_W+ADDR_W-1:0] rom_addr,
  input  logic [UOP_W-1:0]        rom_data,
  output logic [UOP_W-1:0]        uop,
  output logic                    uop_valid,
  input  logic                    uop_ack,
  output logic [ADDR_W:0]         uop_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_LOAD = 2'd2,
    S_EXEC = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [SEL_W-1:0]        sel_q, sel_d;
  logic [ADDR_W-1:0]       pc_q, pc_d;
  logic [SEL_W+ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [UOP_W-1:0]        uop_q, uop_d;
  logic                    uop_valid_q, uop_valid_d;
  logic [ADDR_W:0]         uop_cnt_q, uop_cnt_d;
  logic                    rdy_q, rdy_d;
  logic                    err_q, err_d;

  logic [ADDR_W-1:0]       pc_inc;
  logic [OPCODE_W-1:0]     opcode;

  assign pc_inc = pc_q + ADDR_W'(1);
  assign opcode = rom_data[UOP_W-1 -: OPCODE_W];

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    pc_d        = pc_q;
    rom_addr_d  = rom_addr_q;
    uop_d       = uop_q;
    uop_valid_d = uop_valid_q;
    uop_cnt_d   = uop_cnt_q;
    rdy_d       = rdy_q;
    err_d       = err_q;

    case (state_q)
      S_IDLE: begin
        if (ena) begin
          sel_d      = prog_sel;
          pc_d       = '0;
          rom_addr_d = {prog_sel, {ADDR_W{1'b0}}};
          rdy_d      = 1'b0;
          err_d      = 1'b0;
          uop_cnt_d  = '0;
          state_d    = S_ADDR;
        end
      end
      // The ROM registers the address issued on entry here; its word is
      // only visible on rom_data one clock later.
      S_ADDR: state_d = S_LOAD;
      S_LOAD: begin
        if (opcode == OPCODE_RDY) begin
          rdy_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          uop_d       = rom_data;
          uop_valid_d = 1'b1;
          state_d     = S_EXEC;
        end
      end
      S_EXEC: begin
        if (uop_ack) begin
          uop_valid_d = 1'b0;
          uop_cnt_d   = uop_cnt_q + (ADDR_W+1)'(1);
          if (pc_q != {ADDR_W{1'b1}}) begin
            pc_d       = pc_inc;
            rom_addr_d = {sel_q, pc_inc};
            state_d    = S_ADDR;
          end else begin
            // Last word of the program executed without finding RDY.
            err_d   = 1'b1;
            rdy_d   = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      sel_q       <= '0;
      pc_q        <= '0;
      rom_addr_q  <= '0;
      uop_q       <= '0;
      uop_valid_q <= 1'b0;
      uop_cnt_q   <= '0;
      rdy_q       <= 1'b1;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      pc_q        <= pc_d;
      rom_addr_q  <= rom_addr_d;
      uop_q       <= uop_d;
      uop_valid_q <= uop_valid_d;
      uop_cnt_q   <= uop_cnt_d;
      rdy_q       <= rdy_d;
      err_q       <= err_d;
    end
  end

  assign rdy       = rdy_q;
  assign err       = err_q;
  assign rom_addr  = rom_addr_q;
  assign uop       = uop_q;
  assign uop_valid = uop_valid_q;
  assign uop_cnt   = uop_cnt_q;

endmodule
`default_nettype wire
